// File: rtl/melody_player.sv
// Loadable melody sequencer: plays notes from a small write-port memory as a square wave
// on the buzzer pin, with tempo set by parameters and start/stop/pause/mute control.
module melody_player #(
    parameter int CLK_HZ  = 100_000_000,
    parameter int TICK_HZ = 4,
    parameter int DEPTH   = 64,
    parameter int DIV_W   = 18,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          stop,
    input  logic          pause,
    input  logic          loop_en,
    input  logic          en,
    input  logic [AW-1:0] last_idx,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [8:0]    wr_note,
    output logic          audio,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] note_idx,
    output logic [1:0]    state_dbg
);

    localparam int TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int TW       = $clog2(TICK_DIV + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    // Octave-major order: low 1..7, mid 1..7, high 1..7.
    localparam int FREQ [21] = '{
        262, 294, 330, 349, 392, 440, 494,
        523, 587, 659, 698, 784, 880, 988,
        1047, 1175, 1319, 1397, 1568, 1760, 1976
    };

    function automatic logic [DIV_W-1:0] half_calc(input int f);
        int h;
        h = CLK_HZ / (2 * f);
        if (h < 1) h = 1;
        return DIV_W'(h);
    endfunction

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        PLAY = 2'd2
    } state_t;

    state_t            state, state_next;
    logic [8:0]        mem [DEPTH];
    logic [8:0]        note_q;
    logic [AW-1:0]     idx_next, last_q, last_next;
    logic              done_next, note_end;
    logic [TW-1:0]     tick_cnt;
    logic [3:0]        beat_cnt;
    logic [DIV_W-1:0]  half_cnt;
    logic              tone_reg;
    logic [DIV_W-1:0]  half_tab [21];
    logic [DIV_W-1:0]  half_sel;
    logic [4:0]        tab_idx;
    logic [3:0]        dur;
    logic [1:0]        oct;
    logic [2:0]        deg;
    logic              is_rest;

    for (genvar g = 0; g < 21; g++) begin : g_half
        localparam logic [DIV_W-1:0] H = half_calc(FREQ[g]);
        assign half_tab[g] = H;
    end

    assign dur      = note_q[8:5];
    assign oct      = note_q[4:3];
    assign deg      = note_q[2:0];
    assign is_rest  = (oct == 2'd3) || (deg == 3'd0);
    assign tab_idx  = ({3'b000, oct} * 5'd7) + {2'b00, deg} - 5'd1;
    assign half_sel = half_tab[is_rest ? 5'd0 : tab_idx];

    // Memory has no reset; a same-cycle write to the loading address yields the old word.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_note;
        if (state == LOAD) note_q <= mem[note_idx];
    end

    always_comb begin
        state_next = state;
        idx_next   = note_idx;
        last_next  = last_q;
        done_next  = 1'b0;
        note_end   = (beat_cnt == dur) && (tick_cnt == TICK_LAST) && !pause;
        case (state)
            IDLE: begin
                if (start && !stop) begin
                    state_next = LOAD;
                    idx_next   = '0;
                    last_next  = last_idx;
                end
            end
            LOAD: state_next = stop ? IDLE : PLAY;
            PLAY: begin
                if (stop) begin
                    state_next = IDLE;
                end else if (note_end) begin
                    if (note_idx != last_q) begin
                        idx_next   = note_idx + AW'(1);
                        state_next = LOAD;
                    end else if (loop_en) begin
                        idx_next   = '0;
                        state_next = LOAD;
                    end else begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            note_idx <= '0;
            last_q   <= '0;
            done     <= 1'b0;
            busy     <= 1'b0;
            tick_cnt <= '0;
            beat_cnt <= '0;
            half_cnt <= '0;
            tone_reg <= 1'b0;
        end else begin
            state    <= state_next;
            note_idx <= idx_next;
            last_q   <= last_next;
            done     <= done_next;
            busy     <= (state_next != IDLE);
            // Counters only run while staying in PLAY; any other cycle restarts the note cleanly.
            if (state != PLAY || state_next != PLAY) begin
                tick_cnt <= '0;
                beat_cnt <= '0;
                half_cnt <= '0;
                tone_reg <= 1'b0;
            end else if (pause) begin
                tone_reg <= 1'b0;
            end else begin
                if (tick_cnt == TICK_LAST) begin
                    tick_cnt <= '0;
                    beat_cnt <= beat_cnt + 4'd1;
                end else begin
                    tick_cnt <= tick_cnt + TW'(1);
                end
                if (is_rest) begin
                    tone_reg <= 1'b0;
                    half_cnt <= '0;
                end else if (half_cnt == half_sel - DIV_W'(1)) begin
                    tone_reg <= ~tone_reg;
                    half_cnt <= '0;
                end else begin
                    half_cnt <= half_cnt + DIV_W'(1);
                end
            end
        end
    end

    assign audio     = en & tone_reg;
    assign state_dbg = state;

endmodule
